// File: rtl/fixed_point_multiplier_if.sv
// Operand load, start/done handshake and result bus of the fixed-point multiplier.
interface fixed_point_multiplier_if #(
   parameter int W = 10
);
   logic         start;
   logic         ld_a;
   logic         ld_b;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic [W-1:0] p;
   logic         ov;
   logic         busy;
   logic         done;

   modport master (
      output start, ld_a, ld_b, A, B,
      input  p, ov, busy, done
   );

   modport slave (
      input  start, ld_a, ld_b, A, B,
      output p, ov, busy, done
   );
endinterface

// File: rtl/fixed_point_multiplier.sv
// Sequential unsigned Q(W-FRAC).FRAC shift-add multiplier.
// Recomputes A = q*B so fixed-point divider results can be checked in-system.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; operand snapshot taken on accept
// RUN    | one shift-add iteration per cycle, W cycles in total
// FINISH | scale/truncate product into p, set ov, pulse done
module fixed_point_multiplier #(
   parameter int W    = 10,
   parameter int FRAC = 5
) (
   input logic                 clk,
   input logic                 rst,
   fixed_point_multiplier_if.slave bus
);

   localparam int CW = $clog2(W);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] RUN    = 2'd1;
   localparam logic [1:0] FINISH = 2'd2;

   logic [1:0]     state;
   logic [W-1:0]   a_reg;
   logic [W-1:0]   b_reg;
   logic [2*W-1:0] prod;
   logic [W-1:0]   mcand;
   logic [W-1:0]   mplier;
   logic [CW-1:0]  cnt;
   logic [W:0]     sum;
   logic [W-1:0]   p_r;
   logic           ov_r;
   logic           done_r;

   // Operand registers load independently of the FSM; the FSM copies them at accept.
   always_ff @(posedge clk) begin
      if (!rst) begin
         a_reg <= '0;
         b_reg <= '0;
      end else begin
         if (bus.ld_a) a_reg <= bus.A;
         if (bus.ld_b) b_reg <= bus.B;
      end
   end

   // Upper half of the product plus the multiplicand when the current multiplier bit is set.
   always_comb begin
      sum = {1'b0, prod[2*W-1:W]} + {1'b0, (mplier[0] ? mcand : '0)};
   end

   // Sequencing FSM and shift-add datapath.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= IDLE;
         prod   <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
         p_r    <= '0;
         ov_r   <= 1'b0;
         done_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  prod   <= '0;
                  mcand  <= a_reg;
                  mplier <= b_reg;
                  cnt    <= '0;
                  state  <= RUN;
               end
            end
            RUN: begin
               // Carry of the add becomes the new MSB after the right shift.
               prod   <= {sum, prod[W-1:1]};
               mplier <= mplier >> 1;
               cnt    <= cnt + 1'b1;
               if (cnt == CW'(W - 1)) state <= FINISH;
            end
            FINISH: begin
               // Truncating scale; anything above the integer field is reported, not saturated.
               p_r    <= prod[FRAC+W-1:FRAC];
               ov_r   <= |prod[2*W-1:FRAC+W];
               done_r <= 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy = (state != IDLE);
   assign bus.p    = p_r;
   assign bus.ov   = ov_r;
   assign bus.done = done_r;

endmodule

// File: tb/tb_fixed_point_multiplier.sv
// Directed-vector bench for fixed_point_multiplier at W=10, FRAC=5 (Q5.5).
module tb_fixed_point_multiplier;

   localparam int W = 10;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   fixed_point_multiplier_if #(.W(W)) bus ();

   fixed_point_multiplier #(.W(W), .FRAC(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs driven and outputs sampled here.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic do_a, input logic do_b);
      bus.A    = a;
      bus.B    = b;
      bus.ld_a = do_a;
      bus.ld_b = do_b;
      step();
      bus.ld_a = 1'b0;
      bus.ld_b = 1'b0;
   endtask

   // Pulse start, wait for done (bounded), check latency, p, ov and return to idle.
   task automatic go(input string tag, input logic [W-1:0] ep, input logic eov);
      int lat;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      lat = 99;
      for (int n = 1; n <= 30; n++) begin
         step();
         if (bus.done) begin
            lat = n;
            break;
         end
      end
      chk({tag, "_lat"}, lat, 32'd11);
      chk({tag, "_p"}, 32'(bus.p), 32'(ep));
      chk({tag, "_ov"}, 32'(bus.ov), 32'(eov));
      step();
      chk({tag, "_done_1cyc"}, 32'(bus.done), 32'd0);
      chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      int ndone;
      n_cmp     = 0;
      n_err     = 0;
      rst       = 1'b0;
      bus.start = 1'b0;
      bus.ld_a  = 1'b0;
      bus.ld_b  = 1'b0;
      bus.A     = '0;
      bus.B     = '0;
      step();
      step();
      chk("rst_p", 32'(bus.p), 32'd0);
      chk("rst_ov", 32'(bus.ov), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      rst = 1'b1;
      step();

      // 1.5 * 2.25 = 3.375
      load(10'd48, 10'd72, 1'b1, 1'b1);
      go("basic", 10'd108, 1'b0);
      // 1023 * 64 = 65472 -> scaled 2046, wraps to 1022
      load(10'd1023, 10'd64, 1'b1, 1'b1);
      go("ovf", 10'd1022, 1'b1);
      load(10'd1, 10'd1, 1'b1, 1'b1);
      go("trunc", 10'd0, 1'b0);
      load(10'd0, 10'd1023, 1'b1, 1'b1);
      go("zero", 10'd0, 1'b0);
      load(10'd32, 10'd1023, 1'b1, 1'b1);
      go("unity", 10'd1023, 1'b0);

      // Load and start while running: snapshot kept, second start dropped.
      load(10'd48, 10'd72, 1'b1, 1'b1);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      step();
      step();
      bus.A     = 10'd1023;
      bus.ld_a  = 1'b1;
      bus.start = 1'b1;
      step();
      bus.ld_a  = 1'b0;
      bus.start = 1'b0;
      ndone = 0;
      for (int n = 4; n <= 30; n++) begin
         if (bus.done) begin
            ndone++;
            chk("snap_p", 32'(bus.p), 32'd108);
            chk("snap_ov", 32'(bus.ov), 32'd0);
         end
         step();
      end
      chk("snap_ndone", ndone, 32'd1);
      // a_reg now 1023, b_reg 72: 73656 -> scaled 2301, wraps to 253, ov
      go("snap_areg", 10'd253, 1'b1);

      // Start together with ld_b: old b_reg (72) used, new (64) used next time.
      load(10'd32, 10'd72, 1'b1, 1'b1);
      bus.B    = 10'd64;
      bus.ld_b = 1'b1;
      bus.start = 1'b1;
      step();
      bus.ld_b  = 1'b0;
      bus.start = 1'b0;
      ndone = 0;
      for (int n = 1; n <= 30; n++) begin
         if (bus.done) begin
            ndone++;
            chk("same_p", 32'(bus.p), 32'd72);
         end
         step();
      end
      chk("same_ndone", ndone, 32'd1);
      go("same_next", 10'd64, 1'b0);

      // Reset mid-operation.
      load(10'd48, 10'd72, 1'b1, 1'b1);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int n = 1; n < 5; n++) step();
      rst = 1'b0;
      step();
      chk("mrst_busy", 32'(bus.busy), 32'd0);
      chk("mrst_p", 32'(bus.p), 32'd0);
      chk("mrst_ov", 32'(bus.ov), 32'd0);
      rst = 1'b1;
      ndone = 0;
      for (int n = 0; n < 20; n++) begin
         if (bus.done) ndone++;
         step();
      end
      chk("mrst_nodone", ndone, 32'd0);
      // a_reg must be cleared: 0 * 2.0 = 0
      load(10'd0, 10'd64, 1'b0, 1'b1);
      go("mrst_areg", 10'd0, 1'b0);
      load(10'd48, 10'd72, 1'b1, 1'b1);
      go("mrst_fresh", 10'd108, 1'b0);

      // Start held high: accepted every 12 cycles, operands reloaded during RUN.
      load(10'd48, 10'd72, 1'b1, 1'b1);
      bus.start = 1'b1;
      step();
      for (int c = 1; c <= 36; c++) begin
         if (c == 2) begin
            bus.A = 10'd1023; bus.B = 10'd64; bus.ld_a = 1'b1; bus.ld_b = 1'b1;
         end else if (c == 14) begin
            bus.A = 10'd32; bus.B = 10'd1023; bus.ld_a = 1'b1; bus.ld_b = 1'b1;
         end
         step();
         bus.ld_a = 1'b0;
         bus.ld_b = 1'b0;
         chk($sformatf("b2b_done_c%0d", c), 32'(bus.done),
             32'((c == 11) || (c == 23) || (c == 35)));
         if (c == 11) begin
            chk("b2b_p1", 32'(bus.p), 32'd108);
            chk("b2b_ov1", 32'(bus.ov), 32'd0);
         end else if (c == 23) begin
            chk("b2b_p2", 32'(bus.p), 32'd1022);
            chk("b2b_ov2", 32'(bus.ov), 32'd1);
         end else if (c == 35) begin
            chk("b2b_p3", 32'(bus.p), 32'd1023);
            chk("b2b_ov3", 32'(bus.ov), 32'd0);
         end
      end
      bus.start = 1'b0;
      step();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fixed_point_multiplier.md
# fixed_point_multiplier

Sequential unsigned fixed-point shift-add multiplier; the inverse datapath of the team's fixed-point divider. It recomputes A = q·B so divider results can be checked in-system. Operands load through dedicated register strobes, a start pulse launches a W-iteration multiply, and a one-cycle done pulse presents the truncated product with an overflow flag.

## Interface
- W, default 10: operand and result width in bits.
- FRAC, default 5: number of fractional bits. Operands and result all use unsigned Q(W-FRAC).FRAC; the default format is Q5.5.
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-low reset, sampled on the rising edge of clk.
- start, input, 1: launches a multiply; accepted only in IDLE.
- ld_a, input, 1: loads A into operand register a_reg.
- ld_b, input, 1: loads B into operand register b_reg.
- A, input, W: multiplicand.
- B, input, W: multiplier.
- p, output, W: registered product; holds its value between operations.
- ov, output, 1: registered overflow flag for the last product.
- busy, output, 1: high whenever the state is not IDLE.
- done, output, 1: one-cycle pulse when p and ov update.

## Operation
- Operand registers:
  - ld_a/ld_b load A/B at the edge. They are independent of the FSM and allowed in any state.
  - A multiply uses snapshots taken at the start edge, so loads during RUN or FINISH do not affect the in-flight operation.
  - If ld_x and start are sampled in the same cycle, the multiply uses the register value from before that edge.
- Datapath: 2W-bit product register P, W-bit multiplicand snapshot M, W-bit multiplier shift register Q, log2(W)-bit iteration counter cnt.
- FSM states:
  - IDLE: if start=1 → RUN; P←0, M←a_reg, Q←b_reg, cnt←0. Otherwise stay.
  - RUN: each cycle, if Q[0], add M into P[2W-1:W] using a (W+1)-bit sum with carry. Then shift {carry, P} right by 1, and shift Q right by 1. cnt increments; at cnt=W-1 → FINISH.
  - FINISH: p←P[FRAC+W-1:FRAC], ov←|P[2W-1:FRAC+W], done←1 → IDLE.
- Product is exact (2W bits) before scaling. Scaling truncates, i.e. rounds toward zero; there is no rounding.
- ov=1 iff the integer part exceeds W-FRAC bits. p then holds the low W bits of the scaled product (wrap, no saturation).
- start while busy is ignored. It is not queued.
- Reset (rst=0 at edge):
  - state←IDLE; p←0, ov←0, done←0; a_reg←0, b_reg←0; P, Q, cnt←0.
  - busy=0 in the cycle after the reset edge.
- Reset mid-operation aborts the operation; no done pulse is produced for it.

## Timing
- Edge 0 samples start=1 in IDLE. busy is high from after edge 0 until edge W+1.
- Edges 1..W perform the W iterations.
- Edge W+1 (FINISH) registers p and ov and raises done. done is high for exactly the one cycle between edges W+1 and W+2.
- Latency from the start edge to done visible is W+1 cycles (11 at default).
- State is IDLE after edge W+1, so start can be accepted at edge W+2 at the earliest. Minimum issue interval is W+2 cycles.
- p and ov change only at a FINISH edge or a reset edge.
- busy is decoded from state; all other outputs are registered.

## Test plan
- Basic multiply: reset; ld_a with A=48 (1.5), ld_b with B=72 (2.25); start. Required: done exactly 11 cycles after the start edge, p=108 (3.375), ov=0, busy low the cycle after done.
- Overflow: A=1023, B=64 (2.0). Required: raw product 65472, p=1022, ov=1.
- Truncation and zero:
  - A=1, B=1 → p=0, ov=0.
  - A=0, B=1023 → p=0, ov=0.
  - A=32 (1.0), B=1023 → p=1023, ov=0.
- Snapshot and ignore:
  - Start with A=48, B=72. At cycle 3, pulse ld_a with A=1023 and pulse start. Required: single done, p=108; a_reg=1023 afterward.
  - Start in the same cycle as ld_b with B=64: multiply uses the old b_reg.
- Reset mid-operation: start A=48, B=72; drive rst=0 at cycle 5. Required: no done pulse, busy=0, p=0, ov=0, registers cleared. A fresh start after release gives correct results.
- Back-to-back: issue a start every cycle with alternating operands. Required: operations accepted only every 12 cycles (W+2), each with the correct p/ov and a one-cycle done.
